canny_accel_hls_deadlock_report_unit: RTL and testbench
=======================================================

# canny_accel_hls_deadlock_report_unit

Collects the per-process `dl_detect_out` flags from every `canny_accel_hls_deadlock_detect_unit` in the accelerator. It arbitrates one origin process and broadcasts the global deadlock flag back to all detect units as their `dl_detect_in`. It then drives the token round that traces the dependency cycle, and latches a report with the origin index, the set of processes in the cycle, and a timeout flag.

## Interface
Parameters:
- `PROC_NUM`, 4: number of dataflow processes (one detect unit each).
- `CYCLE_LIMIT`, 16: maximum TRACE cycles allowed before the round is declared timed out; must be ≥ 2.

Ports:
- `clock`  in  1  sole clock; all registers are rising-edge.
- `reset`  in  1  asynchronous, active-high; clears every register immediately.
- `dl_in_vec`  in  PROC_NUM  bit i is `dl_detect_out` of process i.
- `token_ret_vec`  in  PROC_NUM  bit i is the OR-reduced `token_in_vec` of process i, meaning the token has reached process i.
- `report_ack`  in  1  consumer acknowledge; releases DONE.
- `dl_detect_out`  out  1  registered global deadlock flag, fanned out to every unit's `dl_detect_in`.
- `origin`  out  PROC_NUM  registered one-hot single-cycle pulse; bit i drives `origin` of unit i.
- `token_clear`  out  1  combinational; fanned out to every unit's `token_clear`.
- `dl_proc_vec`  out  PROC_NUM  registered accumulated set of processes reached by the token.
- `report_origin`  out  $clog2(PROC_NUM) (min 1)  registered index of the origin process.
- `report_valid`  out  1  registered; high while in DONE.
- `report_timeout`  out  1  registered; qualifies `report_valid`.

## Operation
- FSM states: IDLE, TRACE, DONE. Reset enters IDLE.
- Cycle counter `cnt` is $clog2(CYCLE_LIMIT+1) bits. It saturates and never wraps.
- IDLE:
  - If `|dl_in_vec`, capture `k`, the lowest set index of `dl_in_vec`. The priority encoder works LSB-first, so simultaneous detections resolve to the lowest index.
  - Next cycle: `dl_detect_out`=1, `origin`=onehot(k), `report_origin`=k, `dl_proc_vec`=onehot(k), `cnt`=0, state TRACE.
  - While no flag is set, IDLE holds.
- TRACE:
  - `origin` returns to 0 after its single cycle.
  - Every cycle: `dl_proc_vec` |= `token_ret_vec`, and `cnt` increments.
  - Return detected: `cnt` ≥ 1 and `token_ret_vec[report_origin]`=1.
    - `token_clear`=1 in that same cycle. This stops the origin unit re-forwarding the token.
    - Next state DONE with `report_timeout`=0.
  - Timeout: no return and `cnt` = CYCLE_LIMIT−1 → next state DONE with `report_timeout`=1, `token_clear` not asserted.
  - If return and timeout coincide, the return wins (`report_timeout`=0).
  - `dl_in_vec` and `report_ack` are ignored in TRACE.
- DONE:
  - `report_valid`=1. `dl_detect_out` stays 1.
  - `dl_proc_vec`, `report_origin` and `report_timeout` are frozen.
  - `report_ack`=1 → next cycle IDLE with all outputs 0. A new `dl_in_vec` may launch from the following IDLE cycle.
- `token_clear` = (state==TRACE) & (cnt≥1) & `token_ret_vec[report_origin]`. It is 0 in every other state.

## Timing
- Reset values: every output is 0. State is IDLE and `cnt`=0.
- Reset mid-TRACE or mid-DONE: outputs go to 0 asynchronously, with no pulse completion.
- Launch latency: `dl_in_vec` set at edge N (IDLE) → `dl_detect_out`, `origin` and TRACE visible after edge N+1. `origin` drops after edge N+2.
- Token return at TRACE cycle T:
  - `token_clear` is high during T.
  - `report_valid` rises after the next edge.
  - `token_ret_vec` bits sampled in cycle T are included in `dl_proc_vec`.
- Timeout: `report_valid` rises exactly CYCLE_LIMIT cycles after TRACE entry.
- Ack: `report_ack` sampled high in DONE → outputs clear one edge later.

## Test plan
- **Single detector:** PROC_NUM=4, `dl_in_vec`=0100 one cycle.
  - Required: `origin`=0100 for exactly one cycle and `report_origin`=2.
  - Drive `token_ret_vec` bits 3,0,2 on successive TRACE cycles.
  - Required: `token_clear` high with bit 2, then `report_valid`=1, `dl_proc_vec`=1101, `report_timeout`=0.
- **Simultaneous detection:** `dl_in_vec`=1010 → `report_origin`=1, `origin`=0010. A later `dl_in_vec`=0001 during TRACE is ignored.
- **Timeout:** CYCLE_LIMIT=16, never return the token.
  - Required: `report_valid`=1 and `report_timeout`=1 exactly 16 cycles after TRACE entry; `token_clear` never asserted.
  - Return on the same cycle as `cnt`=15 → `report_timeout`=0.
- **Ack and relaunch:** `report_ack` in DONE → all outputs 0 next cycle. `dl_in_vec`=0001 then relaunches with `report_origin`=0. `report_ack` asserted during TRACE has no effect.
- **Reset:** assert `reset` mid-TRACE, asynchronously between edges. Required: all outputs 0 before the next edge, and state IDLE on release.

Source files
------------

// File: rtl/canny_accel_hls_deadlock_report_unit.sv
// Deadlock report unit: picks the lowest-index detecting process as origin, broadcasts the
// global deadlock flag, follows the token round and latches the resulting cycle report.
module canny_accel_hls_deadlock_report_unit #(
  parameter int PROC_NUM    = 4,
  parameter int CYCLE_LIMIT = 16,
  localparam int RW = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1,
  localparam int CW = $clog2(CYCLE_LIMIT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                report_ack,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic [PROC_NUM-1:0] dl_proc_vec,
  output logic [RW-1:0]       report_origin,
  output logic                report_valid,
  output logic                report_timeout,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic                any_dl;
  logic [RW-1:0]       first_idx;
  logic [PROC_NUM-1:0] first_onehot;
  logic                ret_hit;
  logic                at_limit;

  // LSB-first priority: scanning downward lets the lowest set index win.
  always_comb begin
    first_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_in_vec[i]) first_idx = RW'(i);
    end
  end

  assign any_dl       = |dl_in_vec;
  assign first_onehot = PROC_NUM'(1) << first_idx;

  // The token is in flight during the first TRACE cycle, so a return only counts from cnt>=1.
  assign ret_hit     = (state == TRACE) && (cnt != '0) && token_ret_vec[report_origin];
  assign at_limit    = (cnt == CW'(CYCLE_LIMIT - 1));
  assign token_clear = ret_hit;
  assign fsm_state   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_dl) state_next = TRACE;
      TRACE:   if (ret_hit || at_limit) state_next = DONE;
      DONE:    if (report_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      dl_detect_out  <= 1'b0;
      origin         <= '0;
      dl_proc_vec    <= '0;
      report_origin  <= '0;
      report_valid   <= 1'b0;
      report_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_dl) begin
            dl_detect_out <= 1'b1;
            origin        <= first_onehot;
            report_origin <= first_idx;
            dl_proc_vec   <= first_onehot;
            cnt           <= '0;
          end
        end
        TRACE: begin
          origin      <= '0;
          dl_proc_vec <= dl_proc_vec | token_ret_vec;
          if (cnt != CW'(CYCLE_LIMIT)) cnt <= cnt + CW'(1);
          // A return on the last allowed cycle still counts as a clean return.
          if (ret_hit) begin
            report_valid   <= 1'b1;
            report_timeout <= 1'b0;
          end else if (at_limit) begin
            report_valid   <= 1'b1;
            report_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (report_ack) begin
            cnt            <= '0;
            dl_detect_out  <= 1'b0;
            origin         <= '0;
            dl_proc_vec    <= '0;
            report_origin  <= '0;
            report_valid   <= 1'b0;
            report_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canny_accel_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed and random token rounds, reports checked
// by a monitor against a queue filled from a round-level reference model.
module tb_canny_accel_hls_deadlock_report_unit;

  localparam int P  = 4;
  localparam int L  = 16;
  localparam int RW = 2;
  localparam int W  = 2 * P + RW + 1 + 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [P-1:0]  dl_in_vec;
  logic [P-1:0]  token_ret_vec;
  logic          report_ack;
  logic          dl_detect_out;
  logic [P-1:0]  origin;
  logic          token_clear;
  logic [P-1:0]  dl_proc_vec;
  logic [RW-1:0] report_origin;
  logic          report_valid;
  logic          report_timeout;
  logic [1:0]    fsm_state;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q[$];

  canny_accel_hls_deadlock_report_unit #(.PROC_NUM(P), .CYCLE_LIMIT(L)) dut (
    .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec), .token_ret_vec(token_ret_vec),
    .report_ack(report_ack), .dl_detect_out(dl_detect_out), .origin(origin),
    .token_clear(token_clear), .dl_proc_vec(dl_proc_vec), .report_origin(report_origin),
    .report_valid(report_valid), .report_timeout(report_timeout), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got stuck required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else passed++;
  endtask

  // Round-level model: origin is the lowest detecting process; the round ends at the first
  // cycle t>=1 where the origin sees the token, or times out after L cycles.
  function automatic logic [W-1:0] model(input logic [P-1:0] launch,
                                         input logic [P-1:0] rets [L],
                                         output int tend, output logic tmo);
    int idx;
    logic [P-1:0] procs;
    bit found, done;
    idx = 0;
    found = 0;
    for (int i = 0; i < P; i++) begin
      if (launch[i] && !found) begin
        idx = i;
        found = 1;
      end
    end
    procs = '0;
    procs[idx] = 1'b1;
    tend = L - 1;
    tmo = 1'b1;
    done = 0;
    for (int t = 0; t < L; t++) begin
      if (!done) begin
        procs = procs | rets[t];
        if (t >= 1 && rets[t][idx]) begin
          tend = t;
          tmo = 1'b0;
          done = 1;
        end
      end
    end
    model = {P'(1 << idx), RW'(idx), procs, tmo, 8'(tend + 1)};
  endfunction

  // monitor: one report per rising report_valid, compared against the queue head
  int cyc = 0, start_cyc = 0, org_cnt = 0;
  logic [P-1:0] org_seen = '0;
  logic prev_dl = 1'b0, prev_rv = 1'b0;
  logic [W-1:0] mon_e;

  always @(negedge clock) begin
    if (reset) begin
      prev_dl = 1'b0;
      prev_rv = 1'b0;
      org_cnt = 0;
      org_seen = '0;
    end else begin
      cyc++;
      if (dl_detect_out && !prev_dl) start_cyc = cyc;
      if (origin != '0) begin
        org_cnt++;
        org_seen = origin;
      end
      if (report_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_report", 32'(report_valid), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("origin_onehot", 32'(org_seen), 32'(mon_e[18:15]));
          check("origin_pulse_len", 32'(org_cnt), 32'd1);
          check("report_origin", 32'(report_origin), 32'(mon_e[14:13]));
          check("dl_proc_vec", 32'(dl_proc_vec), 32'(mon_e[12:9]));
          check("report_timeout", 32'(report_timeout), 32'(mon_e[8]));
          check("report_latency", 32'(cyc - start_cyc), 32'(mon_e[7:0]));
        end
        org_cnt = 0;
        org_seen = '0;
      end
      prev_dl = dl_detect_out;
      prev_rv = report_valid;
    end
  end

  function automatic logic [31:0] all_outputs();
    all_outputs = 32'({dl_detect_out, origin, token_clear, dl_proc_vec, report_origin,
                       report_valid, report_timeout});
  endfunction

  // driver: called at posedge+1 with the DUT idle
  task automatic run_txn(input logic [P-1:0] launch, input logic [P-1:0] rets [L],
                         input int abort_req);
    logic [W-1:0] e;
    int tend, abort_t, hold;
    logic tmo;
    bit aborted;
    e = model(launch, rets, tend, tmo);
    abort_t = (abort_req > tend) ? -1 : abort_req;
    if (abort_t < 0) exp_q.push_back(e);
    dl_in_vec = launch;
    @(posedge clock); #1;
    aborted = 0;
    for (int t = 0; t <= tend && !aborted; t++) begin
      token_ret_vec = rets[t];
      dl_in_vec = P'($urandom);
      report_ack = 1'($urandom_range(0, 1));
      if (t == abort_t) begin
        #2 reset = 1'b1;
        #1 check("reset_async_outputs", all_outputs(), 32'd0);
        #3 reset = 1'b0;
        token_ret_vec = '0;
        dl_in_vec = '0;
        report_ack = 1'b0;
        #1 check("reset_state_idle", 32'(fsm_state), 32'd0);
        aborted = 1;
      end else begin
        @(negedge clock);
        check("token_clear", 32'(token_clear), 32'((t == tend) && !tmo));
        @(posedge clock); #1;
      end
    end
    if (!aborted) begin
      token_ret_vec = '0;
      dl_in_vec = '0;
      report_ack = 1'b0;
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clock);
        check("done_hold_valid", 32'({report_valid, dl_detect_out}), 32'd3);
        @(posedge clock); #1;
      end
      report_ack = 1'b1;
      @(posedge clock); #1;
      report_ack = 1'b0;
      check("ack_clears_outputs", all_outputs(), 32'd0);
      check("ack_state_idle", 32'(fsm_state), 32'd0);
    end
  endtask

  logic [P-1:0] rets [L];
  logic [P-1:0] launch;
  int oi, abort_req;

  task automatic clear_rets();
    for (int t = 0; t < L; t++) rets[t] = '0;
  endtask

  initial begin
    reset = 1'b1;
    dl_in_vec = '0;
    token_ret_vec = '0;
    report_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // single detector, token visits 3, 0, then returns to 2
    clear_rets();
    rets[0] = 4'b1000; rets[1] = 4'b0001; rets[2] = 4'b0100;
    run_txn(4'b0100, rets, -1);
    // simultaneous detection resolves to process 1
    clear_rets();
    rets[1] = 4'b0100; rets[3] = 4'b0010;
    run_txn(4'b1010, rets, -1);
    // pure timeout
    clear_rets();
    run_txn(4'b0001, rets, -1);
    // return on the last allowed cycle beats the timeout
    clear_rets();
    rets[0] = 4'b1000; rets[15] = 4'b1001;
    run_txn(4'b1000, rets, -1);
    // relaunch with the quickest possible return
    clear_rets();
    rets[1] = 4'b0001;
    run_txn(4'b0001, rets, -1);
    // reset mid-round, then a normal round
    clear_rets();
    run_txn(4'b0010, rets, 3);
    clear_rets();
    rets[2] = 4'b0110;
    run_txn(4'b0110, rets, -1);

    for (int n = 0; n < 40; n++) begin
      launch = P'($urandom_range(1, (1 << P) - 1));
      oi = 0;
      for (int i = P - 1; i >= 0; i--) if (launch[i]) oi = i;
      for (int t = 0; t < L; t++) begin
        rets[t] = P'($urandom);
        if (t >= 1 && $urandom_range(0, 5) != 0) rets[t][oi] = 1'b0;
      end
      abort_req = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      run_txn(launch, rets, abort_req);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
